// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
//   Shared definitions for the execute-stage multiply/divide unit and the
//   decoder that drives it: MD_ctr operation encodings, default latencies and
//   a helper that sizes the busy countdown counter.
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

    // MD_ctr encodings. 3'b110 and 3'b111 are unused and have no effect.
    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    // Default busy periods, counted in edges after the Start edge.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Counter width able to hold the larger of the two latencies.
    function automatic int cnt_width(input int mult_cycles, input int div_cycles);
        int max_c;
        max_c = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return (max_c < 2) ? 1 : $clog2(max_c + 1);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Execute-stage multiply/divide unit that owns the HI/LO registers.
//   mult/multu/div/divu are computed combinationally when accepted, held in
//   hi_t/lo_t, and committed to HI/LO after a fixed busy countdown.
//   mthi/mtlo write D1 straight into HI/LO with no busy period.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-low reset
//   D1         in   32  rs operand (forwarded)
//   D2         in   32  rt operand (forwarded)
//   MD_ctr     in   3   operation select (md_op_e)
//   Start      in   1   mult/multu/div/divu in E this cycle
//   Enmultdiv  in   1   any MD instruction in E, including mthi/mtlo
//   Cancel     in   1   exception taken this cycle; E instruction is void
//   Busy       out  1   Start | operation in flight (combinational)
//   HI         out  32  HI register
//   LO         out  32  LO register
//
// Handshake: an operation is accepted at a rising edge when
//   Enmultdiv & ~Cancel & (cnt == 0). Hazard logic must hold any MD or
//   MFHI/MFLO instruction in D while Busy is high; an operation presented
//   while a countdown is running is dropped without any state change.
//   An operation already in flight always completes, even under Cancel.
// -----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic [2:0]  MD_ctr,
    input  logic        Start,
    input  logic        Enmultdiv,
    input  logic        Cancel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      hi_t_q, hi_t_d;
    logic [31:0]      lo_t_q, lo_t_d;
    logic             dz_q, dz_d;

    logic             idle;
    logic             accept;

    // Arithmetic datapath
    logic signed [63:0] sa64, sb64, prod_s;
    logic [63:0]        ua64, ub64, prod_u;
    logic signed [31:0] sa, sb_safe, squot, srem;
    logic [31:0]        ub_safe, uquot, urem;
    logic               div_zero, div_ovf;

    assign sa64   = {{32{D1[31]}}, D1};
    assign sb64   = {{32{D2[31]}}, D2};
    assign prod_s = sa64 * sb64;
    assign ua64   = {32'd0, D1};
    assign ub64   = {32'd0, D2};
    assign prod_u = ua64 * ub64;

    assign div_zero = (D2 == 32'd0);
    // 0x80000000 / -1 overflows; dividing by +1 instead yields exactly the
    // required LO=0x80000000, HI=0. A zero divisor is also replaced by 1 so
    // the operator never sees zero; that result is never committed.
    assign div_ovf  = (D1 == 32'h8000_0000) && (D2 == 32'hFFFF_FFFF);
    assign sa       = D1;
    assign sb_safe  = (div_zero || div_ovf) ? 32'sd1 : D2;
    assign squot    = sa / sb_safe;
    assign srem     = sa % sb_safe;
    assign ub_safe  = div_zero ? 32'd1 : D2;
    assign uquot    = D1 / ub_safe;
    assign urem     = D1 % ub_safe;

    assign idle   = (cnt_q == '0);
    assign accept = Enmultdiv && !Cancel && idle;
    assign Busy   = Start || !idle;
    assign HI     = hi_q;
    assign LO     = lo_q;

    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        hi_t_d = hi_t_q;
        lo_t_d = lo_t_q;
        dz_d   = dz_q;

        if (!idle) begin
            cnt_d = cnt_q - CNT_W'(1);
            // Final edge of the countdown commits, unless the divisor was zero.
            if (cnt_q == CNT_W'(1) && !dz_q) begin
                hi_d = hi_t_q;
                lo_d = lo_t_q;
            end
        end else if (accept) begin
            case (MD_ctr)
                MD_MULT: if (Start) begin
                    {hi_t_d, lo_t_d} = prod_s;
                    dz_d             = 1'b0;
                    cnt_d            = CNT_W'(MULT_CYCLES);
                end
                MD_MULTU: if (Start) begin
                    {hi_t_d, lo_t_d} = prod_u;
                    dz_d             = 1'b0;
                    cnt_d            = CNT_W'(MULT_CYCLES);
                end
                MD_DIV: if (Start) begin
                    hi_t_d = srem;
                    lo_t_d = squot;
                    dz_d   = div_zero;
                    cnt_d  = CNT_W'(DIV_CYCLES);
                end
                MD_DIVU: if (Start) begin
                    hi_t_d = urem;
                    lo_t_d = uquot;
                    dz_d   = div_zero;
                    cnt_d  = CNT_W'(DIV_CYCLES);
                end
                MD_MTHI: hi_d = D1;
                MD_MTLO: lo_d = D1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            hi_t_q <= '0;
            lo_t_q <= '0;
            dz_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            hi_t_q <= hi_t_d;
            lo_t_q <= lo_t_d;
            dz_q   <= dz_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit: directed cases for each operation,
//   divide by zero, cancel, reset mid-operation and unused encodings, followed
//   by randomized operations checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clk;
    logic        reset;
    logic [31:0] D1, D2;
    logic [2:0]  MD_ctr;
    logic        Start, Enmultdiv, Cancel;
    logic        Busy;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_errors = 0;

    // Reference HI/LO and pending results ({hi, lo}) awaiting commit.
    logic [31:0] model_hi, model_lo;
    logic [63:0] exp_q[$];

    mult_div_unit #(
        .MULT_CYCLES(MULT_LAT),
        .DIV_CYCLES (DIV_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .D1        (D1),
        .D2        (D2),
        .MD_ctr    (MD_ctr),
        .Start     (Start),
        .Enmultdiv (Enmultdiv),
        .Cancel    (Cancel),
        .Busy      (Busy),
        .HI        (HI),
        .LO        (LO)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Computes {hi, lo} from the arithmetic definitions; commit=0 on divide by zero.
    task automatic ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [63:0] res, output logic commit);
        longint          sa, sb, ma, mb, q, r, p;
        longint unsigned ua, ub, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        commit = 1'b1;
        res    = '0;
        case (op)
            OP_MULT: begin
                p   = sa * sb;
                res = p;
            end
            OP_MULTU: begin
                pu  = ua * ub;
                res = pu;
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    commit = 1'b0;
                end else begin
                    // Magnitude division, then apply signs: quotient toward zero,
                    // remainder follows the dividend.
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                    q  = ma / mb;
                    r  = ma % mb;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    if (sa < 0) r = -r;
                    res = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    commit = 1'b0;
                end else begin
                    q   = longint'(ua / ub);
                    r   = longint'(ua % ub);
                    res = {r[31:0], q[31:0]};
                end
            end
            default: commit = 1'b0;
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic drive_idle();
        Enmultdiv = 1'b0;
        Start     = 1'b0;
        Cancel    = 1'b0;
        MD_ctr    = 3'($urandom_range(0, 7));
        D1        = $urandom;
        D2        = $urandom;
    endtask

    // Present one instruction in E for one cycle and follow it to completion.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cancel);
        logic        is_arith;
        logic [63:0] res;
        logic        commit;
        int          lat;
        is_arith = (op <= OP_DIVU);
        lat      = (op <= OP_MULTU) ? MULT_LAT : DIV_LAT;

        @(negedge clk);
        check_val("idle_before_issue", {31'd0, Busy}, 32'd0);
        Enmultdiv = 1'b1;
        Start     = is_arith;
        Cancel    = cancel;
        MD_ctr    = op;
        D1        = a;
        D2        = b;
        #1;
        check_val("busy_start_cycle", {31'd0, Busy}, {31'd0, is_arith});

        @(posedge clk);
        #1;
        drive_idle();

        if (is_arith && !cancel) begin
            ref_result(op, a, b, res, commit);
            exp_q.push_back(commit ? res : {model_hi, model_lo});
            for (int i = 1; i <= lat; i++) begin
                @(negedge clk);
                check_val("busy_in_flight", {31'd0, Busy}, 32'd1);
                check_val("hi_before_commit", HI, model_hi);
                check_val("lo_before_commit", LO, model_lo);
            end
            {model_hi, model_lo} = exp_q.pop_front();
        end else if (!cancel) begin
            if (op == OP_MTHI) model_hi = a;
            if (op == OP_MTLO) model_lo = a;
        end

        @(negedge clk);
        check_val("busy_done", {31'd0, Busy}, 32'd0);
        check_val("hi_result", HI, model_hi);
        check_val("lo_result", LO, model_lo);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;

        reset    = 1'b0;
        drive_idle();
        model_hi = '0;
        model_lo = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_busy", {31'd0, Busy}, 32'd0);
        check_val("reset_hi", HI, 32'd0);
        check_val("reset_lo", LO, 32'd0);
        reset = 1'b1;

        // Directed cases
        issue(OP_MULT,  32'd3,          32'hFFFF_FFFE, 1'b0);
        check_val("mult_3x-2_hi", HI, 32'hFFFF_FFFF);
        check_val("mult_3x-2_lo", LO, 32'hFFFF_FFFA);
        issue(OP_MULTU, 32'hFFFF_FFFF,  32'd2,         1'b0);
        check_val("multu_hi", HI, 32'h0000_0001);
        check_val("multu_lo", LO, 32'hFFFF_FFFE);
        issue(OP_DIV,   32'hFFFF_FFF9,  32'd2,         1'b0);
        check_val("div_-7/2_lo", LO, 32'hFFFF_FFFD);
        check_val("div_-7/2_hi", HI, 32'hFFFF_FFFF);
        issue(OP_DIVU,  32'hFFFF_FFF9,  32'd2,         1'b0);
        check_val("divu_lo", LO, 32'h7FFF_FFFC);
        check_val("divu_hi", HI, 32'h0000_0001);
        issue(OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
        check_val("div_ovf_lo", LO, 32'h8000_0000);
        check_val("div_ovf_hi", HI, 32'h0000_0000);

        issue(OP_MTHI,  32'h11, 32'd0, 1'b0);
        issue(OP_MTLO,  32'h22, 32'd0, 1'b0);
        issue(OP_DIVU,  32'd5,  32'd0, 1'b0);
        check_val("divzero_hi", HI, 32'h11);
        check_val("divzero_lo", LO, 32'h22);

        // Cancelled start and cancelled mthi leave everything unchanged
        issue(OP_MULT,  32'd7,  32'd9, 1'b1);
        issue(OP_MTHI,  32'hDEAD_BEEF, 32'd0, 1'b1);
        check_val("cancel_mthi_hi", HI, 32'h11);

        // Unused encodings with Enmultdiv have no effect
        issue(3'b110, 32'h1234_5678, 32'd3, 1'b0);
        issue(3'b111, 32'h1234_5678, 32'd3, 1'b0);

        // Reset in the middle of a multiply
        @(negedge clk);
        Enmultdiv = 1'b1;
        Start     = 1'b1;
        MD_ctr    = OP_MULT;
        D1        = 32'd100;
        D2        = 32'd200;
        @(posedge clk);
        #1;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("midreset_busy", {31'd0, Busy}, 32'd0);
        check_val("midreset_hi", HI, 32'd0);
        check_val("midreset_lo", LO, 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        model_hi = '0;
        model_lo = '0;
        repeat (MULT_LAT + 2) begin
            @(negedge clk);
            check_val("no_late_commit_busy", {31'd0, Busy}, 32'd0);
            check_val("no_late_commit_hi", HI, 32'd0);
            check_val("no_late_commit_lo", LO, 32'd0);
        end

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 5));
            a  = pick_operand();
            b  = pick_operand();
            issue(op, a, b, ($urandom_range(0, 7) == 0));
        end

        check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Bound the run so a stuck design still reaches a report.
    initial begin
        #200000;
        n_errors++;
        $display("FAIL timeout: got no end of stimulus expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
